wb_trap_unit: RTL and testbench

- Consumer end of the MEM/WB latch interface.
- Takes the committing WB-stage instruction with its exception vector, flushed flag and CSR/mret controls.
- Decides whether the instruction commits, traps, takes an interrupt, or returns via mret.
- Holds the machine-mode CSRs, and drives pipeline-wide flush, WB write-kill and the PC redirect back to IF.

---
 rtl/wb_trap_unit.sv | 189 ++++++++++++++++++
 tb/tb_wb_trap_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trap_unit.sv
// WB-stage trap unit: decides commit / exception / interrupt / mret and holds the machine-mode CSRs.
// Optional: define WB_TRAP_MTVAL_EN to implement mtval (0x343); otherwise it reads 0 and ignores writes.
module wb_trap_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [XLEN-1:0] pc_wb,
  input  logic [31:0]     ir_wb,
  input  logic [XLEN-1:0] aluo_wb,
  input  logic [3:0]      exp_vector_wb,
  input  logic            is_flushed,
  input  logic            mret_wb,
  input  logic            csr_we,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            irq_ext,
  output logic [XLEN-1:0] csr_rdata,
  output logic            flush,
  output logic            kill_wb,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);
  typedef enum logic {IDLE = 1'b0, TRAP = 1'b1} state_t;

  state_t          state_reg, state_next;
  logic            mie_reg, mie_next, mpie_reg, mpie_next, meie_reg, meie_next;
  logic            irq_pending_reg, irq_pending_next;
  logic [XLEN-1:0] mtvec_reg, mtvec_next, mscratch_reg, mscratch_next;
  logic [XLEN-1:0] mepc_reg, mepc_next, mcause_reg, mcause_next;
`ifdef WB_TRAP_MTVAL_EN
  logic [XLEN-1:0] mtval_reg, mtval_next;
`else
  logic            unused_aluo;
  assign unused_aluo = ^aluo_wb;
`endif

  logic            slot_valid, take_exc, take_irq, take_trap, take_mret, take_csr;
  logic [3:0]      exc_first;
  logic [3:0]      exc_code;
  logic [XLEN-1:0] csr_wval;

  // One-hot of the highest-priority exception (bit 0 = illegal is highest).
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_exc_pri
      if (gi == 0) begin : g_lsb
        assign exc_first[gi] = exp_vector_wb[gi];
      end else begin : g_upper
        assign exc_first[gi] = exp_vector_wb[gi] & ~(|exp_vector_wb[gi-1:0]);
      end
    end
  endgenerate

  always_comb begin
    exc_code = 4'd0;
    if (exc_first[0]) exc_code = 4'd2;
    if (exc_first[1]) exc_code = 4'd11;
    if (exc_first[2]) exc_code = 4'd5;
    if (exc_first[3]) exc_code = 4'd7;
  end

  assign slot_valid = !rst && en && !is_flushed && (ir_wb != 32'd0) && (state_reg == IDLE);
  assign take_exc   = slot_valid && (exp_vector_wb != 4'd0);
  assign take_irq   = slot_valid && !take_exc && irq_pending_reg && mie_reg && meie_reg;
  assign take_trap  = take_exc || take_irq;
  assign take_mret  = slot_valid && !take_trap && mret_wb;
  assign take_csr   = slot_valid && !take_trap && !mret_wb && csr_we && (csr_op != 2'b00);

  assign flush       = take_trap || take_mret;
  assign kill_wb     = take_trap;
  assign redirect    = take_trap || take_mret;
  assign redirect_pc = take_mret ? mepc_reg : mtvec_reg;

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      12'h300: begin
        csr_rdata[3] = mie_reg;
        csr_rdata[7] = mpie_reg;
      end
      12'h304: csr_rdata[11] = meie_reg;
      12'h305: csr_rdata = mtvec_reg;
      12'h340: csr_rdata = mscratch_reg;
      12'h341: csr_rdata = mepc_reg;
      12'h342: csr_rdata = mcause_reg;
`ifdef WB_TRAP_MTVAL_EN
      12'h343: csr_rdata = mtval_reg;
`endif
      default: csr_rdata = '0;
    endcase
  end

  always_comb begin
    case (csr_op)
      2'b01:   csr_wval = csr_wdata;
      2'b10:   csr_wval = csr_rdata | csr_wdata;
      2'b11:   csr_wval = csr_rdata & ~csr_wdata;
      default: csr_wval = csr_rdata;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    mie_next      = mie_reg;
    mpie_next     = mpie_reg;
    meie_next     = meie_reg;
    mtvec_next    = mtvec_reg;
    mscratch_next = mscratch_reg;
    mepc_next     = mepc_reg;
    mcause_next   = mcause_reg;
`ifdef WB_TRAP_MTVAL_EN
    mtval_next    = mtval_reg;
`endif
    // Level source keeps re-arming the pending bit even on the cycle it is taken.
    irq_pending_next = irq_ext || (irq_pending_reg && !take_irq);

    if (en && state_reg == TRAP) begin
      state_next = IDLE;
    end else if (take_trap) begin
      state_next  = TRAP;
      mepc_next   = {pc_wb[XLEN-1:2], 2'b00};
      mcause_next = take_exc ? {{(XLEN-4){1'b0}}, exc_code} : {1'b1, {(XLEN-5){1'b0}}, 4'hB};
      mpie_next   = mie_reg;
      mie_next    = 1'b0;
`ifdef WB_TRAP_MTVAL_EN
      if (exc_first[0])
        mtval_next = {{(XLEN-32){1'b0}}, ir_wb};
      else if (exc_first[2] || exc_first[3])
        mtval_next = aluo_wb;
      else
        mtval_next = '0;
`endif
    end else if (take_mret) begin
      state_next = TRAP;
      mie_next   = mpie_reg;
      mpie_next  = 1'b1;
    end else if (take_csr) begin
      case (csr_addr)
        12'h300: begin
          mie_next  = csr_wval[3];
          mpie_next = csr_wval[7];
        end
        12'h304: meie_next     = csr_wval[11];
        12'h305: mtvec_next    = {csr_wval[XLEN-1:2], 2'b00};
        12'h340: mscratch_next = csr_wval;
        12'h341: mepc_next     = {csr_wval[XLEN-1:2], 2'b00};
        12'h342: mcause_next   = csr_wval;
`ifdef WB_TRAP_MTVAL_EN
        12'h343: mtval_next    = csr_wval;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      mie_reg         <= 1'b0;
      mpie_reg        <= 1'b0;
      meie_reg        <= 1'b0;
      irq_pending_reg <= 1'b0;
      mtvec_reg       <= {MTVEC_RESET[XLEN-1:2], 2'b00};
      mscratch_reg    <= '0;
      mepc_reg        <= '0;
      mcause_reg      <= '0;
`ifdef WB_TRAP_MTVAL_EN
      mtval_reg       <= '0;
`endif
    end else begin
      state_reg       <= state_next;
      mie_reg         <= mie_next;
      mpie_reg        <= mpie_next;
      meie_reg        <= meie_next;
      irq_pending_reg <= irq_pending_next;
      mtvec_reg       <= mtvec_next;
      mscratch_reg    <= mscratch_next;
      mepc_reg        <= mepc_next;
      mcause_reg      <= mcause_next;
`ifdef WB_TRAP_MTVAL_EN
      mtval_reg       <= mtval_next;
`endif
    end
  end
endmodule

// File: tb/tb_wb_trap_unit.sv
// Bench for wb_trap_unit: directed scenarios plus randomized traffic against a CSR-level reference model.
`timescale 1ns/1ps
module tb_wb_trap_unit;
  localparam logic [31:0] MTVEC_RST = 32'h0000_0100;
`ifdef WB_TRAP_MTVAL_EN
  localparam bit MTVAL_ON = 1'b1;
`else
  localparam bit MTVAL_ON = 1'b0;
`endif
  localparam int EV_NONE = 0, EV_EXC = 1, EV_IRQ = 2, EV_MRET = 3, EV_CSR = 4, EV_COMMIT = 5;

  logic        clk = 1'b0;
  logic        rst, en, is_flushed, mret_wb, csr_we, irq_ext;
  logic [31:0] pc_wb, ir_wb, aluo_wb, csr_wdata;
  logic [3:0]  exp_vector_wb;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata, redirect_pc;
  logic        flush, kill_wb, redirect;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_trap_unit #(.XLEN(32), .MTVEC_RESET(MTVEC_RST)) dut (
    .clk(clk), .rst(rst), .en(en), .pc_wb(pc_wb), .ir_wb(ir_wb), .aluo_wb(aluo_wb),
    .exp_vector_wb(exp_vector_wb), .is_flushed(is_flushed), .mret_wb(mret_wb),
    .csr_we(csr_we), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .irq_ext(irq_ext), .csr_rdata(csr_rdata), .flush(flush), .kill_wb(kill_wb),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  // Reference model: architectural CSR fields plus "one bubble owed after a redirect".
  bit          m_mie, m_mpie, m_meie, m_pend, m_busy;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;

  task automatic m_reset();
    m_mie = 0; m_mpie = 0; m_meie = 0; m_pend = 0; m_busy = 0;
    m_mtvec = MTVEC_RST; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return (m_mie ? 32'd8 : 32'd0) + (m_mpie ? 32'd128 : 32'd0);
      12'h304: return m_meie ? 32'h800 : 32'd0;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return MTVAL_ON ? m_mtval : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_write(input logic [11:0] a, input logic [31:0] v);
    case (a)
      12'h300: begin m_mie = v[3]; m_mpie = v[7]; end
      12'h304: m_meie = v[11];
      12'h305: m_mtvec = v & 32'hFFFF_FFFC;
      12'h340: m_mscratch = v;
      12'h341: m_mepc = v & 32'hFFFF_FFFC;
      12'h342: m_mcause = v;
      12'h343: m_mtval = v;
      default: ;
    endcase
  endtask

  function automatic int m_event();
    if (rst || !en || is_flushed || ir_wb == 0 || m_busy) return EV_NONE;
    if (exp_vector_wb != 0) return EV_EXC;
    if (m_pend && m_mie && m_meie) return EV_IRQ;
    if (mret_wb) return EV_MRET;
    if (csr_we && csr_op != 0) return EV_CSR;
    return EV_COMMIT;
  endfunction

  task automatic model_edge();
    int ev;
    logic [31:0] old_v, new_v;
    if (rst) return;
    ev = m_event();
    if (ev == EV_IRQ) m_pend = 0;
    if (irq_ext) m_pend = 1;
    if (!en) return;
    if (m_busy) begin m_busy = 0; return; end
    case (ev)
      EV_EXC, EV_IRQ: begin
        m_mepc = pc_wb & 32'hFFFF_FFFC;
        m_mtval = 0;
        if (ev == EV_IRQ) m_mcause = 32'h8000_000B;
        else if (exp_vector_wb[0]) begin m_mcause = 2; m_mtval = ir_wb; end
        else if (exp_vector_wb[1]) m_mcause = 11;
        else if (exp_vector_wb[2]) begin m_mcause = 5; m_mtval = aluo_wb; end
        else begin m_mcause = 7; m_mtval = aluo_wb; end
        m_mpie = m_mie; m_mie = 0; m_busy = 1;
      end
      EV_MRET: begin m_mie = m_mpie; m_mpie = 1; m_busy = 1; end
      EV_CSR: begin
        old_v = m_read(csr_addr);
        new_v = (csr_op == 1) ? csr_wdata : (csr_op == 2) ? (old_v | csr_wdata) : (old_v & ~csr_wdata);
        m_write(csr_addr, new_v);
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_slot(input logic [31:0] pc, input logic [31:0] ir, input logic [31:0] aluo,
                            input logic [3:0] ex, input logic mr, input logic we,
                            input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    en = 1; is_flushed = 0; irq_ext = 0;
    pc_wb = pc; ir_wb = ir; aluo_wb = aluo; exp_vector_wb = ex; mret_wb = mr;
    csr_we = we; csr_op = op; csr_addr = addr; csr_wdata = wd;
    #1;
  endtask

  task automatic bubble(input logic [11:0] addr);
    drive_slot(0, 0, 0, 0, 0, 0, 0, addr, 0);
  endtask

  task automatic test_reset();
    logic [11:0] zaddr [6] = '{12'h300, 12'h304, 12'h340, 12'h341, 12'h342, 12'h343};
    m_reset();
    rst = 1;
    drive_slot(32'h40, 32'hFFFF_FFFF, 0, 4'b0001, 0, 0, 0, 12'h305, 0);
    n_tests++; if (csr_rdata !== 32'h100) begin n_fail++; $display("FAIL reset_mtvec got %h want 00000100", csr_rdata); end
    n_tests++; if ({flush, kill_wb, redirect} !== 3'b000) begin n_fail++; $display("FAIL reset_outs got %b want 000", {flush, kill_wb, redirect}); end
    for (int i = 0; i < 6; i++) begin
      bubble(zaddr[i]);
      n_tests++; if (csr_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_csr_%h got %h want 0", zaddr[i], csr_rdata); end
    end
    tick();
    rst = 0;
    $display("[TB] test_reset done");
  endtask

  task automatic test_illegal();
    drive_slot(32'h40, 32'hFFFF_FFFF, 0, 4'b0001, 0, 0, 0, 12'h0, 0);
    n_tests++; if ({flush, kill_wb, redirect} !== 3'b111) begin n_fail++; $display("FAIL illegal_outs got %b want 111", {flush, kill_wb, redirect}); end
    n_tests++; if (redirect_pc !== 32'h100) begin n_fail++; $display("FAIL illegal_pc got %h want 00000100", redirect_pc); end
    tick();
    drive_slot(32'h44, 32'hFFFF_FFFF, 0, 4'b0001, 0, 0, 0, 12'h0, 0);
    n_tests++; if ({flush, kill_wb, redirect} !== 3'b000) begin n_fail++; $display("FAIL illegal_next_ignored got %b want 000", {flush, kill_wb, redirect}); end
    tick();
    bubble(12'h341);
    n_tests++; if (csr_rdata !== 32'h40) begin n_fail++; $display("FAIL illegal_mepc got %h want 00000040", csr_rdata); end
    bubble(12'h342);
    n_tests++; if (csr_rdata !== 32'd2) begin n_fail++; $display("FAIL illegal_mcause got %h want 2", csr_rdata); end
    bubble(12'h343);
    n_tests++; if (csr_rdata !== (MTVAL_ON ? 32'hFFFF_FFFF : 32'd0)) begin n_fail++; $display("FAIL illegal_mtval got %h", csr_rdata); end
    tick();
    $display("[TB] test_illegal done");
  endtask

  task automatic test_ecall_mret();
    drive_slot(32'h7C, 32'h3004_2073, 0, 0, 0, 1, 2'b10, 12'h300, 32'h8);
    n_tests++; if (csr_rdata !== 32'd0 || flush !== 1'b0) begin n_fail++; $display("FAIL csrrs_mstatus rdata %h flush %b want 0 0", csr_rdata, flush); end
    tick();
    drive_slot(32'h80, 32'h0000_0073, 0, 4'b0010, 0, 0, 0, 12'h0, 0);
    n_tests++; if ({flush, kill_wb, redirect} !== 3'b111) begin n_fail++; $display("FAIL ecall_outs got %b want 111", {flush, kill_wb, redirect}); end
    tick(); bubble(12'h0); tick();
    bubble(12'h342);
    n_tests++; if (csr_rdata !== 32'd11) begin n_fail++; $display("FAIL ecall_mcause got %h want 0000000b", csr_rdata); end
    bubble(12'h300);
    n_tests++; if (csr_rdata !== 32'h80) begin n_fail++; $display("FAIL ecall_mstatus got %h want 00000080", csr_rdata); end
    drive_slot(32'h84, 32'h3020_0073, 0, 0, 1, 0, 0, 12'h0, 0);
    n_tests++; if ({flush, kill_wb, redirect} !== 3'b101) begin n_fail++; $display("FAIL mret_outs got %b want 101", {flush, kill_wb, redirect}); end
    n_tests++; if (redirect_pc !== 32'h80) begin n_fail++; $display("FAIL mret_pc got %h want 00000080", redirect_pc); end
    tick(); bubble(12'h0); tick();
    bubble(12'h300);
    n_tests++; if (csr_rdata !== 32'h88) begin n_fail++; $display("FAIL mret_mstatus got %h want 00000088", csr_rdata); end
    $display("[TB] test_ecall_mret done");
  endtask

  task automatic test_irq();
    bubble(12'h0); irq_ext = 1; tick(); irq_ext = 0;
    drive_slot(32'h90, 32'h13, 0, 0, 0, 0, 0, 12'h0, 0);
    n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL irq_masked_flush got %b want 0", flush); end
    tick();
    drive_slot(32'h92, 32'h3040_1073, 0, 0, 0, 1, 2'b01, 12'h304, 32'h800);
    n_tests++; if (flush !== 1'b0 || csr_rdata !== 32'd0) begin n_fail++; $display("FAIL irq_meie_write flush %b rdata %h want 0 0", flush, csr_rdata); end
    tick();
    drive_slot(32'h94, 32'h13, 0, 0, 0, 0, 0, 12'h0, 0);
    n_tests++; if ({flush, kill_wb, redirect} !== 3'b111 || redirect_pc !== 32'h100) begin n_fail++; $display("FAIL irq_take outs %b pc %h want 111 00000100", {flush, kill_wb, redirect}, redirect_pc); end
    tick(); bubble(12'h0); tick();
    bubble(12'h342);
    n_tests++; if (csr_rdata !== 32'h8000_000B) begin n_fail++; $display("FAIL irq_mcause got %h want 8000000b", csr_rdata); end
    drive_slot(32'h98, 32'h3020_0073, 0, 0, 1, 0, 0, 12'h0, 0);
    n_tests++; if (redirect_pc !== 32'h94 || kill_wb !== 1'b0) begin n_fail++; $display("FAIL irq_mret pc %h kill %b want 00000094 0", redirect_pc, kill_wb); end
    tick(); bubble(12'h0); tick();
    drive_slot(32'h94, 32'h13, 0, 0, 0, 0, 0, 12'h0, 0);
    n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL irq_cleared flush got %b want 0", flush); end
    tick();
    $display("[TB] test_irq done");
  endtask

  task automatic test_exc_vs_irq();
    bubble(12'h0); irq_ext = 1; tick(); irq_ext = 0;
    drive_slot(32'hA0, 32'h00A1_2023, 32'hDEAD_0000, 4'b1000, 0, 0, 0, 12'h0, 0);
    n_tests++; if ({flush, kill_wb, redirect} !== 3'b111) begin n_fail++; $display("FAIL store_outs got %b want 111", {flush, kill_wb, redirect}); end
    tick(); bubble(12'h0); tick();
    bubble(12'h342);
    n_tests++; if (csr_rdata !== 32'd7) begin n_fail++; $display("FAIL store_mcause got %h want 7", csr_rdata); end
    bubble(12'h343);
    n_tests++; if (csr_rdata !== (MTVAL_ON ? 32'hDEAD_0000 : 32'd0)) begin n_fail++; $display("FAIL store_mtval got %h", csr_rdata); end
    drive_slot(32'hA4, 32'h3020_0073, 0, 0, 1, 0, 0, 12'h0, 0);
    n_tests++; if ({flush, kill_wb} !== 2'b10 || redirect_pc !== 32'hA0) begin n_fail++; $display("FAIL store_mret outs %b pc %h want 10 000000a0", {flush, kill_wb}, redirect_pc); end
    tick(); bubble(12'h0); tick();
    drive_slot(32'hA8, 32'h13, 0, 0, 0, 0, 0, 12'h0, 0);
    n_tests++; if (kill_wb !== 1'b1) begin n_fail++; $display("FAIL irq_still_pending kill got %b want 1", kill_wb); end
    tick(); bubble(12'h0); tick();
    bubble(12'h342);
    n_tests++; if (csr_rdata !== 32'h8000_000B) begin n_fail++; $display("FAIL pending_mcause got %h want 8000000b", csr_rdata); end
    $display("[TB] test_exc_vs_irq done");
  endtask

  task automatic test_stall();
    logic [31:0] mepc_before;
    mepc_before = m_read(12'h341);
    for (int i = 0; i < 3; i++) begin
      drive_slot(32'h200, 32'hFFFF_FFFF, 0, 4'b0001, 0, 0, 0, 12'h341, 0);
      en = 0; #1;
      n_tests++; if ({flush, kill_wb, redirect} !== 3'b000 || csr_rdata !== mepc_before) begin
        n_fail++; $display("FAIL stall_%0d outs %b mepc %h want 000 %h", i, {flush, kill_wb, redirect}, csr_rdata, mepc_before);
      end
      tick();
    end
    en = 1; #1;
    n_tests++; if (flush !== 1'b1 || redirect_pc !== 32'h100) begin n_fail++; $display("FAIL stall_release flush %b pc %h want 1 00000100", flush, redirect_pc); end
    tick();
    n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL stall_once flush got %b want 0", flush); end
    tick();
    bubble(12'h341);
    n_tests++; if (csr_rdata !== 32'h200) begin n_fail++; $display("FAIL stall_mepc got %h want 00000200", csr_rdata); end
    $display("[TB] test_stall done");
  endtask

  task automatic test_random();
    logic [11:0] addrs [9] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h7C0, 12'h301};
    int ev;
    bit e_flush, e_kill;
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 3) != 0);
      is_flushed = ($urandom_range(0, 9) == 0);
      ir_wb = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
      pc_wb = $urandom; aluo_wb = $urandom;
      exp_vector_wb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      mret_wb = ($urandom_range(0, 9) == 0);
      csr_we = ($urandom_range(0, 2) == 0);
      csr_op = 2'($urandom_range(0, 3));
      csr_addr = addrs[$urandom_range(0, 8)];
      csr_wdata = $urandom;
      irq_ext = ($urandom_range(0, 6) == 0);
      #1;
      ev = m_event();
      e_flush = (ev == EV_EXC) || (ev == EV_IRQ) || (ev == EV_MRET);
      e_kill = (ev == EV_EXC) || (ev == EV_IRQ);
      n_tests++; if ({flush, kill_wb, redirect} !== {e_flush, e_kill, e_flush}) begin
        n_fail++; $display("FAIL rnd_%0d_outs got %b want %b", i, {flush, kill_wb, redirect}, {e_flush, e_kill, e_flush});
      end
      if (e_flush) begin
        n_tests++; if (redirect_pc !== ((ev == EV_MRET) ? m_mepc : m_mtvec)) begin
          n_fail++; $display("FAIL rnd_%0d_pc got %h want %h", i, redirect_pc, (ev == EV_MRET) ? m_mepc : m_mtvec);
        end
      end
      n_tests++; if (csr_rdata !== m_read(csr_addr)) begin
        n_fail++; $display("FAIL rnd_%0d_rdata addr %h got %h want %h", i, csr_addr, csr_rdata, m_read(csr_addr));
      end
      $display("[TB] rnd %0d ev=%0d flush=%0b kill=%0b pc=%h", i, ev, flush, kill_wb, redirect_pc);
      tick();
    end
  endtask

  task automatic test_reset_mid_trap();
    bubble(12'h0); tick(); tick();
    drive_slot(32'h10, 32'h3050_1073, 0, 0, 0, 1, 2'b01, 12'h305, 32'h2000);
    tick(); bubble(12'h0); tick();
    drive_slot(32'h300, 32'hFFFF_FFFF, 0, 4'b0001, 0, 0, 0, 12'h305, 0);
    n_tests++; if (flush !== 1'b1 || redirect_pc !== m_mtvec) begin n_fail++; $display("FAIL midrst_pre flush %b pc %h want 1 %h", flush, redirect_pc, m_mtvec); end
    rst = 1; #1;
    m_reset();
    n_tests++; if (flush !== 1'b0 || csr_rdata !== 32'h100) begin n_fail++; $display("FAIL midrst_async flush %b mtvec %h want 0 00000100", flush, csr_rdata); end
    tick();
    rst = 0;
    bubble(12'h341);
    n_tests++; if (csr_rdata !== 32'd0) begin n_fail++; $display("FAIL midrst_mepc got %h want 0", csr_rdata); end
    bubble(12'h342);
    n_tests++; if (csr_rdata !== 32'd0) begin n_fail++; $display("FAIL midrst_mcause got %h want 0", csr_rdata); end
    $display("[TB] test_reset_mid_trap done");
  endtask

  initial begin
    rst = 1; en = 0; is_flushed = 0; mret_wb = 0; csr_we = 0; irq_ext = 0;
    pc_wb = 0; ir_wb = 0; aluo_wb = 0; csr_wdata = 0; exp_vector_wb = 0; csr_op = 0; csr_addr = 0;
    #2;
    test_reset();
    test_illegal();
    test_ecall_mret();
    test_irq();
    test_exc_vs_irq();
    test_stall();
    test_random();
    test_reset_mid_trap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
